// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types for the framebuffer access arbiter
// Contents:
//   FB_X_BITS, FB_Y_BITS  framebuffer coordinate widths
//   fb_arb_state_t        arbiter FSM states
//   fb_wr_t               queued pixel write {y, x, data}
package vga_pkg;

    localparam int FB_X_BITS = 8;
    localparam int FB_Y_BITS = 8;

    typedef enum logic [1:0] {
        FB_RUN,
        FB_CLR_PEND,
        FB_CLEAR
    } fb_arb_state_t;

    typedef struct packed {
        logic [FB_Y_BITS-1:0] y;
        logic [FB_X_BITS-1:0] x;
        logic                 data;
    } fb_wr_t;

endpackage

// File: rtl/fb_write_fifo.sv
// rtl/fb_write_fifo.sv - synchronous FIFO of pending framebuffer pixel writes
// Ports:
//   vga_clk, reset_n  clock, asynchronous active-low reset
//   push, push_data   enqueue (ignored while full, no bypass)
//   pop               dequeue head (ignored while empty)
//   head              current head entry, valid while !empty
//   full, empty       occupancy flags
module fb_write_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   vga_clk,
    input  logic   reset_n,
    input  logic   push,
    input  fb_wr_t push_data,
    input  logic   pop,
    output fb_wr_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    fb_wr_t      store [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = store[rd_ptr[AW-1:0]];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (push && !full) begin
            store[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - single-port 1-bit framebuffer RAM arbiter
// Ports:
//   vga_clk, reset_n              pixel clock, asynchronous active-low reset
//   scan_active, scan_x, scan_y   scanout read request (display coordinates)
//   scan_pixel                    scanout pixel, one cycle after request
//   wr_valid/wr_ready, wr_x/wr_y/wr_data   queued pixel writes
//   clear_req, clear_value        start full-buffer fill
//   clear_busy, clear_done        fill pending/running, completion pulse
//   mem_addr/mem_we/mem_wdata/mem_rdata    RAM port, addr = {y, x}
// Scanout always wins the RAM; clear and queued writes use the idle cycles.
module fb_access_arbiter
    import vga_pkg::*;
#(
    parameter int X_BITS        = FB_X_BITS,
    parameter int Y_BITS        = FB_Y_BITS,
    parameter int SCALE_SHIFT   = 1,
    parameter int SCAN_X_BITS   = 10,
    parameter int SCAN_Y_BITS   = 10,
    parameter int WR_FIFO_DEPTH = 8
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    input  logic                     scan_active,
    input  logic [SCAN_X_BITS-1:0]   scan_x,
    input  logic [SCAN_Y_BITS-1:0]   scan_y,
    output logic                     scan_pixel,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [X_BITS-1:0]        wr_x,
    input  logic [Y_BITS-1:0]        wr_y,
    input  logic                     wr_data,
    input  logic                     clear_req,
    input  logic                     clear_value,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic [X_BITS+Y_BITS-1:0] mem_addr,
    output logic                     mem_we,
    output logic                     mem_wdata,
    input  logic                     mem_rdata
);

    localparam int A_BITS = X_BITS + Y_BITS;

    fb_arb_state_t     state;
    fb_arb_state_t     state_next;
    logic [A_BITS-1:0] clr_cnt;
    logic [A_BITS-1:0] addr_q;
    logic              clear_val_q;
    logic              scan_q;
    logic              clr_write;
    logic              clr_last;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    fb_wr_t            fifo_in;
    fb_wr_t            fifo_head;
    logic [X_BITS-1:0] scan_fb_x;
    logic [Y_BITS-1:0] scan_fb_y;

    // Display coordinates scale down to FB pixels; excess high bits wrap away.
    assign scan_fb_x = X_BITS'(scan_x >> SCALE_SHIFT);
    assign scan_fb_y = Y_BITS'(scan_y >> SCALE_SHIFT);

    assign fifo_in    = {wr_y, wr_x, wr_data};
    assign wr_ready   = !fifo_full && (state == FB_RUN);
    assign fifo_push  = wr_valid && wr_ready;
    assign clear_busy = (state != FB_RUN);
    assign clr_last   = &clr_cnt;

    // RAM output register already provides the one-cycle delay; only gate it.
    assign scan_pixel = scan_q & mem_rdata;

    fb_write_fifo #(
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Grant: scanout, then clear sweep, then queued writes; idle holds address.
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        fifo_pop  = 1'b0;
        clr_write = 1'b0;
        if (scan_active) begin
            mem_addr = {scan_fb_y, scan_fb_x};
        end else if (state == FB_CLEAR) begin
            mem_addr  = clr_cnt;
            mem_we    = 1'b1;
            mem_wdata = clear_val_q;
            clr_write = 1'b1;
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            mem_addr  = {fifo_head.y, fifo_head.x};
            mem_we    = 1'b1;
            mem_wdata = fifo_head.data;
        end
    end

    // Clear waits in CLR_PEND until writes queued before it have drained.
    always_comb begin
        state_next = state;
        case (state)
            FB_RUN:      if (clear_req)             state_next = FB_CLR_PEND;
            FB_CLR_PEND: if (fifo_empty)            state_next = FB_CLEAR;
            FB_CLEAR:    if (clr_write && clr_last) state_next = FB_RUN;
            default:                                state_next = FB_RUN;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FB_RUN;
            clr_cnt     <= '0;
            addr_q      <= '0;
            clear_val_q <= 1'b0;
            scan_q      <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            state      <= state_next;
            addr_q     <= mem_addr;
            scan_q     <= scan_active;
            clear_done <= clr_write && clr_last;
            if (state == FB_RUN && clear_req) begin
                clear_val_q <= clear_value;
            end
            if (state == FB_CLR_PEND) begin
                clr_cnt <= '0;
            end else if (clr_write) begin
                clr_cnt <= clr_cnt + A_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - randomized self-checking bench for fb_access_arbiter
module tb_fb_access_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_active = 1'b0;
    logic [9:0]  scan_x = '0;
    logic [9:0]  scan_y = '0;
    logic        scan_pixel;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_x = '0;
    logic [7:0]  wr_y = '0;
    logic        wr_data = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_value = 1'b0;
    logic        clear_busy;
    logic        clear_done;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_wdata;
    logic        mem_rdata = 1'b0;

    always #5 vga_clk = ~vga_clk;

    fb_access_arbiter #(
        .X_BITS        (8),
        .Y_BITS        (8),
        .SCALE_SHIFT   (1),
        .SCAN_X_BITS   (10),
        .SCAN_Y_BITS   (10),
        .WR_FIFO_DEPTH (8)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .scan_active (scan_active),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_pixel  (scan_pixel),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Framebuffer RAM: synchronous, read-before-write, one-cycle latency.
    bit ram [65536];
    always @(posedge vga_clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model: a queue of pending writes, a clear phase, a golden image.
    typedef struct {
        int x;
        int y;
        bit d;
    } wr_t;

    wr_t q[$];
    int  phase;       // 0 idle, 1 clear waiting for queue, 2 sweeping
    int  sweep_pos;
    bit  fill_val;
    bit  exp_done;
    bit  exp_pix;
    int  last_addr;
    bit  golden [65536];
    int  total = 0;
    int  bad = 0;
    int  done_pulses;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase     = 0;
        sweep_pos = 0;
        exp_done  = 0;
        exp_pix   = 0;
        last_addr = 0;
    endtask

    task automatic model_cycle();
        int  e_addr;
        bit  e_we;
        bit  e_wd;
        bit  e_ready;
        bit  from_q;
        bit  from_sweep;
        int  qsize0;
        e_ready    = (q.size() < 8) && (phase == 0);
        e_we       = 0;
        e_wd       = 0;
        from_q     = 0;
        from_sweep = 0;
        e_addr     = last_addr;
        if (scan_active) begin
            e_addr = (((int'(scan_y) / 2) % 256) * 256) + ((int'(scan_x) / 2) % 256);
        end else if (phase == 2) begin
            e_addr = sweep_pos; e_we = 1; e_wd = fill_val; from_sweep = 1;
        end else if (q.size() > 0) begin
            e_addr = q[0].y * 256 + q[0].x; e_we = 1; e_wd = q[0].d; from_q = 1;
        end
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("mem_addr", int'(mem_addr), e_addr);
        if (e_we) chk("mem_wdata", int'(mem_wdata), int'(e_wd));
        chk("wr_ready", int'(wr_ready), int'(e_ready));
        chk("clear_busy", int'(clear_busy), int'(phase != 0));
        chk("clear_done", int'(clear_done), int'(exp_done));
        chk("scan_pixel", int'(scan_pixel), int'(exp_pix));
        if (clear_done) done_pulses++;
        // Advance the model across the coming clock edge.
        exp_pix   = scan_active ? golden[e_addr] : 1'b0;
        last_addr = e_addr;
        if (e_we) golden[e_addr] = e_wd;
        qsize0   = q.size();
        exp_done = 0;
        if (phase == 0 && clear_req) begin
            phase = 1; fill_val = clear_value;
        end else if (phase == 1 && qsize0 == 0) begin
            phase = 2; sweep_pos = 0;
        end else if (phase == 2 && from_sweep) begin
            if (sweep_pos == 65535) begin
                phase = 0; exp_done = 1;
            end else begin
                sweep_pos++;
            end
        end
        if (from_q) void'(q.pop_front());
        if (wr_valid && e_ready) q.push_back('{x: int'(wr_x), y: int'(wr_y), d: wr_data});
    endtask

    task automatic step();
        #1;
        model_cycle();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic idle();
        scan_active = 0; wr_valid = 0; clear_req = 0; clear_value = 0;
        scan_x = '0; scan_y = '0; wr_x = '0; wr_y = '0; wr_data = 0;
    endtask

    task automatic randomize_inputs(input int scan_pct, input int wr_pct, input int clr_per);
        scan_active = ($urandom_range(0, 99) < scan_pct);
        scan_x      = 10'($urandom_range(0, 1023));
        scan_y      = 10'($urandom_range(0, 1023));
        wr_valid    = ($urandom_range(0, 99) < wr_pct);
        wr_x        = 8'($urandom_range(0, 255));
        wr_y        = 8'($urandom_range(0, 255));
        wr_data     = 1'($urandom_range(0, 1));
        clear_req   = (clr_per > 0) && ($urandom_range(0, clr_per - 1) == 0);
        clear_value = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wr_ready"}, int'(wr_ready), 1);
        chk({tag, "_clear_busy"}, int'(clear_busy), 0);
        chk({tag, "_clear_done"}, int'(clear_done), 0);
        chk({tag, "_scan_pixel"}, int'(scan_pixel), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    endtask

    initial begin
        int guard;
        int nonfill;
        done_pulses = 0;
        for (int i = 0; i < 65536; i++) golden[i] = 0;
        model_reset();
        idle();
        reset_n = 0;
        @(negedge vga_clk);
        @(negedge vga_clk);
        #1 reset_checks("reset");
        reset_n = 1;
        @(negedge vga_clk);

        // Scanout read of a pixel written through the queue.
        wr_valid = 1; wr_x = 8'd5; wr_y = 8'd2; wr_data = 1;
        step();
        idle();
        #1 chk("t1_write_we", int'(mem_we), 1);
        chk("t1_write_addr", int'(mem_addr), 16'h0205);
        step();
        scan_active = 1; scan_x = 10'd10; scan_y = 10'd4;
        #1 chk("t1_scan_addr", int'(mem_addr), 16'h0205);
        chk("t1_scan_we", int'(mem_we), 0);
        step();
        idle();
        #1 chk("t1_scan_pixel", int'(scan_pixel), 1);
        step();

        // A write waits behind active scanout.
        scan_active = 1; wr_valid = 1; wr_x = 8'd3; wr_y = 8'd7; wr_data = 1;
        step();
        wr_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_blocked_we", int'(mem_we), 0);
            step();
        end
        scan_active = 0;
        #1 chk("t2_we", int'(mem_we), 1);
        chk("t2_addr", int'(mem_addr), 16'h0703);
        step();

        // Fill the queue under scanout, then drain in order.
        scan_active = 1;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1; wr_x = 8'(i); wr_y = 8'(i + 1); wr_data = 1'(i);
            step();
        end
        #1 chk("t3_full_ready", int'(wr_ready), 0);
        step();
        wr_valid = 0; scan_active = 0;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t3_drain_addr", int'(mem_addr), (i + 1) * 256 + i);
            step();
            if (i == 0) chk("t3_ready_after_pop", int'(wr_ready), 1);
        end

        // Random traffic without clears.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs(50, 50, 0);
            step();
        end
        idle();
        repeat (10) step();

        // Reset in the middle of a sweep, then restart from address 0.
        clear_req = 1; clear_value = 1;
        step();
        idle();
        guard = 0;
        while (!(phase == 2 && sweep_pos == 1000) && guard < 3000) begin
            step();
            guard++;
        end
        chk("t6_reached_1000", guard < 3000 ? 1 : 0, 1);
        #1 chk("t6_addr_1000", int'(mem_addr), 1000);
        reset_n = 0;
        model_reset();
        #1 reset_checks("t6_midclear");
        @(negedge vga_clk);
        reset_n = 1;
        step();
        clear_req = 1; clear_value = 0;
        step();
        clear_req = 0;
        step();
        #1 chk("t6_restart_addr", int'(mem_addr), 0);
        chk("t6_restart_we", int'(mem_we), 1);
        done_pulses = 0;
        // Abort the restarted sweep too so the full sweep below starts clean.
        reset_n = 0;
        model_reset();
        #1 reset_checks("t6_second");
        @(negedge vga_clk);
        reset_n = 1;
        step();

        // Three queued writes, then clear together with a fourth write.
        scan_active = 1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_x = 8'(20 + i); wr_y = 8'd30; wr_data = 1;
            step();
        end
        wr_x = 8'd40; wr_y = 8'd40; clear_req = 1; clear_value = 0;
        step();
        idle();
        #1 chk("t4_ready_low", int'(wr_ready), 0);
        chk("t4_busy", int'(clear_busy), 1);
        chk("t4_queued", q.size(), 4);
        guard = 0;
        while (!exp_done && guard < 90000) begin
            randomize_inputs(6, 30, 64);
            step();
            guard++;
        end
        chk("t4_sweep_finished", guard < 90000 ? 1 : 0, 1);
        idle();
        step();
        chk("t4_done_pulses", done_pulses, 1);
        chk("t4_ready_after", int'(wr_ready), 1);
        nonfill = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] != 1'b0) nonfill++;
        chk("t4_ram_all_cleared", nonfill, 0);

        // Random traffic after the sweep, including reads of fresh writes.
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs(40, 60, 0);
            step();
        end
        idle();
        repeat (5) step();
        nonfill = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] != golden[i]) nonfill++;
        chk("final_ram_vs_model", nonfill, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
